uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the next-generation serial input for the MazeRunner core. It oversamples an asynchronous RX line, reconstructs frames with configurable data width, parity and stop bits, and presents each byte with ready/clear handshake plus parity, framing and overrun status. It sits between the board RX pin and the command-processing logic, and replaces fixed 8N1 receivers wherever a different frame format or error reporting is needed.

---
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
// Each completed frame is held with a ready/clear handshake plus parity, framing and overrun status.
module uart_rx_cfg #(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PAR     = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] WAIT_HI = 3'd5;

    localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
    localparam logic        HAS_PAR     = (PARITY != 0);
    localparam logic        ODD_PAR     = (PARITY == 2);

    logic                 sync1_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 facc_q, facc_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 strobe, complete, ferr_now, perr_new;

    assign busy   = (state_q != IDLE);
    assign strobe = busy && (cnt_q == 16'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        facc_d   = facc_q;
        complete = 1'b0;
        ferr_now = facc_q | ~rx_s_q;
        perr_new = HAS_PAR && ((^shift_q ^ par_q) != ODD_PAR);

        if (busy) begin
            cnt_d = strobe ? FULL_RELOAD : cnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d    = HALF_RELOAD;
                    bitcnt_d = 4'd0;
                    state_d  = START;
                end
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (strobe) begin
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = 4'd0;
                        facc_d   = 1'b0;
                        state_d  = HAS_PAR ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (strobe) begin
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    facc_d   = ferr_now;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == LAST_STOP) begin
                        complete = 1'b1;
                        state_d  = ferr_now ? WAIT_HI : IDLE;
                    end
                end
            end
            WAIT_HI: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing frame takes priority over a simultaneous clear.
    always_comb begin
        rdy_d  = rdy_q;
        data_d = data_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (complete) begin
            rdy_d  = 1'b1;
            data_d = shift_q;
            perr_d = perr_new;
            ferr_d = ferr_now;
            ovr_d  = ovr_q | (rdy_q & ~clr_rdy);
        end else if (clr_rdy) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            bitcnt_q <= 4'd0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            facc_q   <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= RX;
            rx_s_q   <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            facc_q   <= facc_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rdy        = rdy_q;
    assign rx_data    = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receivers (8N1, 7E1, 7O1, 8N2) at CLK_DIV = 16.
// Each task drives whole frames bit by bit and compares outputs against hand-computed values.
module tb_uart_rx_cfg;

    localparam int DIV = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] rx_v;
    logic [3:0] clr_v;
    logic [3:0] rdy_v, pe_v, fe_v, ov_v, busy_v;
    logic [7:0] d0, d3;
    logic [6:0] d1, d2;

    int total = 0;
    int bad   = 0;
    int rdy_cycle;

    uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .RX(rx_v[0]), .clr_rdy(clr_v[0]), .rdy(rdy_v[0]),
        .rx_data(d0), .parity_err(pe_v[0]), .frame_err(fe_v[0]), .overrun(ov_v[0]), .busy(busy_v[0]));

    uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .RX(rx_v[1]), .clr_rdy(clr_v[1]), .rdy(rdy_v[1]),
        .rx_data(d1), .parity_err(pe_v[1]), .frame_err(fe_v[1]), .overrun(ov_v[1]), .busy(busy_v[1]));

    uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .RX(rx_v[2]), .clr_rdy(clr_v[2]), .rdy(rdy_v[2]),
        .rx_data(d2), .parity_err(pe_v[2]), .frame_err(fe_v[2]), .overrun(ov_v[2]), .busy(busy_v[2]));

    uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .RX(rx_v[3]), .clr_rdy(clr_v[3]), .rdy(rdy_v[3]),
        .rx_data(d3), .parity_err(pe_v[3]), .frame_err(fe_v[3]), .overrun(ov_v[3]), .busy(busy_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling clock edge; bits[0] is the start bit. rdy_cycle records
    // the first falling edge (counted from the start-bit edge) at which rdy is seen high.
    task automatic send_frame(input int sel, input logic [15:0] bits, input int nbits, input int clr_at);
        int cyc;
        cyc = 0;
        rdy_cycle = -1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < DIV; c++) begin
                rx_v[sel]  = bits[b];
                clr_v[sel] = (cyc == clr_at);
                @(negedge clk);
                cyc++;
                if (rdy_v[sel] && rdy_cycle < 0) rdy_cycle = cyc;
            end
        end
        clr_v[sel] = 1'b0;
    endtask

    task automatic pulse_clr(input int sel);
        clr_v[sel] = 1'b1;
        @(negedge clk);
        clr_v[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rx_v = 4'hF; clr_v = 4'h0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rdy_v !== 4'h0) begin bad++; $display("FAIL reset_rdy got=%b want=0000", rdy_v); end
        total++; if (busy_v !== 4'h0) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy_v); end
        total++; if ({pe_v, fe_v, ov_v} !== 12'h000) begin bad++; $display("FAIL reset_flags got=%h want=000", {pe_v, fe_v, ov_v}); end
        total++; if ({d0, d1, d2, d3} !== 30'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {d0, d1, d2, d3}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, -1);
        total++; if (rdy_cycle !== 155) begin bad++; $display("FAIL basic_latency got=%0d want=155", rdy_cycle); end
        total++; if (d0 !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", d0); end
        total++; if ({pe_v[0], fe_v[0], ov_v[0]} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", {pe_v[0], fe_v[0], ov_v[0]}); end
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy_v[0]); end
        pulse_clr(0);
        total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL basic_clr got=%b want=0", rdy_v[0]); end
        total++; if (d0 !== 8'hA5) begin bad++; $display("FAIL basic_hold got=%h want=a5", d0); end
    endtask

    task automatic test_glitch;
        logic seen_busy;
        seen_busy = 1'b0;
        rx_v[0] = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx_v[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_v[0]) seen_busy = 1'b1;
        end
        total++; if (seen_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse got=%b want=1", seen_busy); end
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL glitch_back_idle got=%b want=0", busy_v[0]); end
        total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL glitch_rdy got=%b want=0", rdy_v[0]); end
    endtask

    task automatic test_parity;
        // 0x35 has four ones: even parity bit 0, odd parity bit 1
        send_frame(1, {1'b1, 1'b0, 7'h35, 1'b0}, 10, -1);
        total++; if ({rdy_v[1], pe_v[1]} !== 2'b10) begin bad++; $display("FAIL even_good got=%b want=10", {rdy_v[1], pe_v[1]}); end
        total++; if (rdy_cycle !== 155) begin bad++; $display("FAIL even_latency got=%0d want=155", rdy_cycle); end
        pulse_clr(1);
        send_frame(1, {1'b1, 1'b1, 7'h35, 1'b0}, 10, -1);
        total++; if ({rdy_v[1], pe_v[1], fe_v[1]} !== 3'b110) begin bad++; $display("FAIL even_bad got=%b want=110", {rdy_v[1], pe_v[1], fe_v[1]}); end
        total++; if (d1 !== 7'h35) begin bad++; $display("FAIL even_bad_data got=%h want=35", d1); end
        pulse_clr(1);
        total++; if (pe_v[1] !== 1'b0) begin bad++; $display("FAIL even_clr_perr got=%b want=0", pe_v[1]); end
        send_frame(2, {1'b1, 1'b1, 7'h35, 1'b0}, 10, -1);
        total++; if ({rdy_v[2], pe_v[2]} !== 2'b10) begin bad++; $display("FAIL odd_good got=%b want=10", {rdy_v[2], pe_v[2]}); end
        total++; if (d2 !== 7'h35) begin bad++; $display("FAIL odd_data got=%h want=35", d2); end
        pulse_clr(2);
        send_frame(2, {1'b1, 1'b0, 7'h35, 1'b0}, 10, -1);
        total++; if (pe_v[2] !== 1'b1) begin bad++; $display("FAIL odd_bad got=%b want=1", pe_v[2]); end
        pulse_clr(2);
    endtask

    task automatic test_stop_break;
        int late_rdy;
        late_rdy = 0;
        send_frame(3, {1'b0, 1'b1, 8'h81, 1'b0}, 11, -1);
        total++; if ({rdy_v[3], fe_v[3], busy_v[3]} !== 3'b111) begin bad++; $display("FAIL break_flags got=%b want=111", {rdy_v[3], fe_v[3], busy_v[3]}); end
        total++; if (d3 !== 8'h81) begin bad++; $display("FAIL break_data got=%h want=81", d3); end
        pulse_clr(3);
        total++; if ({rdy_v[3], fe_v[3]} !== 2'b00) begin bad++; $display("FAIL break_clr got=%b want=00", {rdy_v[3], fe_v[3]}); end
        for (int i = 0; i < 40 * DIV; i++) begin
            @(negedge clk);
            if (rdy_v[3]) late_rdy++;
        end
        total++; if (late_rdy !== 0) begin bad++; $display("FAIL break_no_rdy got=%0d want=0", late_rdy); end
        total++; if (busy_v[3] !== 1'b1) begin bad++; $display("FAIL break_wait_hi got=%b want=1", busy_v[3]); end
        rx_v[3] = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (busy_v[3] !== 1'b0) begin bad++; $display("FAIL break_release got=%b want=0", busy_v[3]); end
        send_frame(3, {2'b11, 8'h3C, 1'b0}, 11, -1);
        total++; if (rdy_cycle !== 171) begin bad++; $display("FAIL stop2_latency got=%0d want=171", rdy_cycle); end
        total++; if ({d3, fe_v[3]} !== {8'h3C, 1'b0}) begin bad++; $display("FAIL stop2_data got=%h/%b want=3c/0", d3, fe_v[3]); end
        pulse_clr(3);
    endtask

    task automatic test_back_to_back;
        send_frame(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        total++; if ({rdy_v[0], d0} !== {1'b1, 8'h11}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/11", rdy_v[0], d0); end
        send_frame(0, {1'b1, 8'h22, 1'b0}, 10, -1);
        total++; if (d0 !== 8'h22) begin bad++; $display("FAIL b2b_second got=%h want=22", d0); end
        total++; if (ov_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b want=1", ov_v[0]); end
        pulse_clr(0);
        total++; if ({rdy_v[0], ov_v[0]} !== 2'b00) begin bad++; $display("FAIL b2b_clr got=%b want=00", {rdy_v[0], ov_v[0]}); end
        send_frame(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        send_frame(0, {1'b1, 8'h22, 1'b0}, 10, 154);
        total++; if ({rdy_v[0], ov_v[0]} !== 2'b10) begin bad++; $display("FAIL b2b_clr_collide got=%b want=10", {rdy_v[0], ov_v[0]}); end
        total++; if (d0 !== 8'h22) begin bad++; $display("FAIL b2b_collide_data got=%h want=22", d0); end
    endtask

    task automatic test_reset_mid;
        send_frame(0, {1'b1, 8'h5A, 1'b0}, 5, -1);
        rx_v[0] = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy_v[0]); end
        rst_n = 1'b0;
        #1;
        total++; if ({rdy_v[0], busy_v[0], pe_v[0], fe_v[0], ov_v[0]} !== 5'b0) begin bad++; $display("FAIL mid_reset_flags got=%b want=00000", {rdy_v[0], busy_v[0], pe_v[0], fe_v[0], ov_v[0]}); end
        total++; if (d0 !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h want=00", d0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, -1);
        total++; if (rdy_cycle !== 155) begin bad++; $display("FAIL after_reset_latency got=%0d want=155", rdy_cycle); end
        total++; if ({d0, pe_v[0], fe_v[0], ov_v[0]} !== {8'h5A, 3'b000}) begin bad++; $display("FAIL after_reset_data got=%h/%b want=5a/000", d0, {pe_v[0], fe_v[0], ov_v[0]}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_parity;
        test_stop_break;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
